ch_arbiter: RTL and testbench
=============================

Name: ch_arbiter

Overview:
- Parametrised successor to the channel priority selector: arbitrates N_CH request lines and issues a registered one-hot grant that is held until release.
- Run-time selectable fixed-priority or round-robin mode, per-channel mask, done-based release, and a hold-time watchdog.
- Sits between the per-channel request logic and the shared encoder datapath. Only the granted channel drives the datapath.

Parameters:
- N_CH, 16, number of channels (>=2).
- HOLD_MAX, 15, maximum grant length in cycles. 0 disables the watchdog.
- CW, $clog2(N_CH), width of the grant index (derived, not overridable).

Ports:
- clk_i  in  1  clock.
- resetn_i  in  1  async reset, active low.
- en_i  in  1  arbiter enable.
- mode_i  in  1  0 = fixed priority (ch0 highest); 1 = round-robin.
- req_i  in  N_CH  per-channel request, level-sensitive.
- mask_i  in  N_CH  1 = channel excluded from arbitration.
- done_i  in  1  granted channel finished; releases the grant.
- gnt_o  out  N_CH  one-hot grant, registered.
- gnt_idx_o  out  CW  binary index of the granted channel, registered.
- gnt_valid_o  out  1  high when gnt_o != 0.
- timeout_o  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Clocking and reset: single clock clk_i; reset resetn_i is asynchronous, active low.
- Reset values: state=IDLE; gnt_o=0; gnt_idx_o=0; gnt_valid_o=0; timeout_o=0; hold counter=0; RR pointer last=N_CH-1, so the first RR grant favours ch0.
- Eligible vector: elig = req_i & ~mask_i, considered only when en_i=1.
- States:
  - IDLE: no grant.
  - GRANT: gnt_o held constant.
  - GAP: one forced-idle turnaround cycle.
- Arbitration runs in IDLE and GAP:
  - Fixed mode: lowest-index set bit of elig.
  - RR mode: first set bit of elig searching last+1, last+2, ... with wrap modulo N_CH.
  - mode_i is sampled only at arbitration. A change during GRANT has no effect until the next arbitration.
- IDLE/GAP -> GRANT when en_i=1 and elig!=0:
  - At the clock edge: gnt_o=onehot(winner), gnt_idx_o=winner, gnt_valid_o=1, counter=0, last=winner.
  - Latency: request sampled in cycle t, grant visible in cycle t+1.
- GAP -> IDLE when there is no eligible request. GAP lasts exactly one cycle.
- GRANT, counter increments each cycle. Release at the next edge on the first matching condition, in this priority order:
  1. en_i=0 -> IDLE. Grant drops, no GAP, no timeout.
  2. done_i=1, or the granted channel's req_i bit is 0, or its mask_i bit is 1 -> GAP, no timeout.
  3. HOLD_MAX!=0 and counter==HOLD_MAX-1 -> GAP, and timeout_o=1 for exactly the GAP cycle.
- On release: gnt_o=0, gnt_valid_o=0. gnt_idx_o holds its last value.
- Max grant length: exactly HOLD_MAX cycles. done_i in the final cycle wins over timeout, so timeout_o stays 0.
- Back-to-back: release edge at t -> GAP in cycle t+1 -> next grant visible in cycle t+2 at the earliest.
- done_i outside GRANT is ignored.
- Counter width is $clog2(HOLD_MAX+1) and it saturates. It never wraps while HOLD_MAX=0.
- gnt_o is always one-hot or zero and never changes value within GRANT.
- Reset asserted mid-grant: all outputs drop immediately (asynchronously) to their reset values. The RR pointer returns to N_CH-1.

Test Plan:
- Fixed mode: en=1, req=0x0014 -> gnt_o=0x0004, idx=2 one cycle later. done pulse -> GAP, then gnt_o=0x0010, idx=4.
- RR fairness: mode=1, req=0x8001 held, done asserted in every grant's first cycle -> grant sequence ch0, ch15, ch0, ch15, each separated by one GAP cycle.
- Mask: req=0x0003, mask=0x0001 -> grant ch1. Setting mask bit1 mid-grant -> release, no timeout_o.
- Watchdog: HOLD_MAX=4, req=0x0001 held, no done -> gnt high exactly 4 cycles, then timeout_o=1 for 1 cycle concurrent with GAP, then ch0 re-granted.
- Done vs. timeout: HOLD_MAX=4, done_i asserted in grant cycle 4 -> release with timeout_o=0. en_i dropped mid-grant -> gnt_o=0 next cycle, state IDLE, no GAP.
- Async reset during GRANT of ch7 -> gnt_o=0, gnt_valid_o=0, gnt_idx_o=0 without a clock edge. After release in RR mode with req=0x0081 -> ch0 granted first.

Source files
------------

// File: rtl/ch_arbiter.sv
// Channel arbiter: fixed-priority or round-robin selection of N_CH requesters,
// registered one-hot grant held until done/drop/mask/disable or watchdog expiry.
module ch_arbiter #(
  parameter int N_CH     = 16,
  parameter int HOLD_MAX = 15
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic                      en_i,
  input  logic                      mode_i,
  input  logic [N_CH-1:0]           req_i,
  input  logic [N_CH-1:0]           mask_i,
  input  logic                      done_i,
  output logic [N_CH-1:0]           gnt_o,
  output logic [$clog2(N_CH)-1:0]   gnt_idx_o,
  output logic                      gnt_valid_o,
  output logic                      timeout_o
);

  localparam int CW    = $clog2(N_CH);
  // A zero-width counter is illegal, so a disabled watchdog still keeps one bit.
  localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
  localparam bit WD_EN = (HOLD_MAX != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;
  localparam logic [CW-1:0]    LAST_RST = CW'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic logic [CW-1:0] pick_fixed(input logic [N_CH-1:0] v);
    logic [CW-1:0] w;
    logic [CW-1:0] ki;
    w = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      ki = CW'(k);
      if (v[ki]) begin
        w = ki;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic logic [CW-1:0] pick_rr(input logic [N_CH-1:0] v,
                                            input logic [CW-1:0]   last);
    logic [CW-1:0] w;
    logic [CW-1:0] ci;
    logic          found;
    w     = '0;
    found = 1'b0;
    for (int k = 1; k <= N_CH; k++) begin
      ci = CW'((int'(last) + k) % N_CH);
      if (!found && v[ci]) begin
        w     = ci;
        found = 1'b1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic logic [N_CH-1:0] onehot(input logic [CW-1:0] idx);
    return {{(N_CH-1){1'b0}}, 1'b1} << idx;
  endfunction

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [CW-1:0]       last_r, last_nxt_s;
  logic [N_CH-1:0]     gnt_nxt_s;
  logic [CW-1:0]       idx_nxt_s;
  logic                valid_nxt_s;
  logic                timeout_nxt_s;
  logic [N_CH-1:0]     elig_s;
  logic [CW-1:0]       winner_s;
  logic                own_req_s;
  logic                own_mask_s;

  assign elig_s     = en_i ? (req_i & ~mask_i) : '0;
  assign winner_s   = mode_i ? pick_rr(elig_s, last_r) : pick_fixed(elig_s);
  assign own_req_s  = |(req_i & gnt_o);
  assign own_mask_s = |(mask_i & gnt_o);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    last_nxt_s    = last_r;
    gnt_nxt_s     = gnt_o;
    idx_nxt_s     = gnt_idx_o;
    valid_nxt_s   = gnt_valid_o;
    timeout_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_GAP: begin
        if (elig_s != '0) begin
          state_nxt_s = ST_GRANT;
          gnt_nxt_s   = onehot(winner_s);
          idx_nxt_s   = winner_s;
          valid_nxt_s = 1'b1;
          cnt_nxt_s   = '0;
          last_nxt_s  = winner_s;
        end else begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
          valid_nxt_s = 1'b0;
        end
      end
      ST_GRANT: begin
        if (!en_i) begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = '0;
          valid_nxt_s = 1'b0;
        end else if (done_i || !own_req_s || own_mask_s) begin
          state_nxt_s = ST_GAP;
          gnt_nxt_s   = '0;
          valid_nxt_s = 1'b0;
        end else if (WD_EN && (cnt_r == CNT_LAST)) begin
          state_nxt_s   = ST_GAP;
          gnt_nxt_s     = '0;
          valid_nxt_s   = 1'b0;
          timeout_nxt_s = 1'b1;
        end else if (cnt_r != CNT_SAT) begin
          cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        gnt_nxt_s   = '0;
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      last_r      <= LAST_RST;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      last_r      <= last_nxt_s;
      gnt_o       <= gnt_nxt_s;
      gnt_idx_o   <= idx_nxt_s;
      gnt_valid_o <= valid_nxt_s;
      timeout_o   <= timeout_nxt_s;
    end
  end

endmodule

// File: tb/tb_ch_arbiter.sv
// Directed bench for ch_arbiter (N_CH=16, HOLD_MAX=4); observes
// {gnt, idx, valid, timeout} one time unit after each rising edge.
module tb_ch_arbiter;

  logic        clk;
  logic        resetn;
  logic        en;
  logic        mode;
  logic [15:0] req;
  logic [15:0] mask;
  logic        done;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;

  logic [21:0] obs;
  logic [21:0] exp_v;
  int          total;
  int          passed;

  assign obs = {gnt, gnt_idx, gnt_valid, timeout};

  ch_arbiter #(.N_CH(16), .HOLD_MAX(4)) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .en_i        (en),
    .mode_i      (mode),
    .req_i       (req),
    .mask_i      (mask),
    .done_i      (done),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    en = 1'b0; mode = 1'b0; req = 16'h0; mask = 16'h0; done = 1'b0;
    tick();
    #2 resetn = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL reset_async got %h want %h", obs, exp_v); else passed++;
    tick();
    total++; if (obs !== exp_v) $display("FAIL reset_held got %h want %h", obs, exp_v); else passed++;
    resetn = 1'b1;
    en = 1'b0; req = 16'hFFFF;
    tick();
    total++; if (obs !== exp_v) $display("FAIL disabled_no_grant got %h want %h", obs, exp_v); else passed++;
    done = 1'b1;
    tick();
    total++; if (obs !== exp_v) $display("FAIL disabled_done got %h want %h", obs, exp_v); else passed++;
    done = 1'b0; req = 16'h0000;
  endtask

  task automatic test_fixed();
    en = 1'b1; mode = 1'b0; req = 16'h0014;
    tick();
    exp_v = {16'h0004, 4'd2, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL fixed_grant got %h want %h", obs, exp_v); else passed++;
    tick();
    total++; if (obs !== exp_v) $display("FAIL fixed_hold got %h want %h", obs, exp_v); else passed++;
    done = 1'b1; req = 16'h0010;
    tick();
    exp_v = {16'h0000, 4'd2, 1'b0, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL fixed_gap got %h want %h", obs, exp_v); else passed++;
    done = 1'b0;
    tick();
    exp_v = {16'h0010, 4'd4, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL fixed_next got %h want %h", obs, exp_v); else passed++;
    req = 16'h0000;
    tick();
    exp_v = {16'h0000, 4'd4, 1'b0, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL fixed_drop got %h want %h", obs, exp_v); else passed++;
    tick();
    total++; if (obs !== exp_v) $display("FAIL fixed_idle got %h want %h", obs, exp_v); else passed++;
  endtask

  task automatic test_rr();
    logic [15:0] eg;
    logic [3:0]  ei;
    apply_reset();
    en = 1'b1; mode = 1'b1; req = 16'h8001;
    tick();
    for (int i = 0; i < 4; i++) begin
      eg = (i % 2 == 1) ? 16'h8000 : 16'h0001;
      ei = (i % 2 == 1) ? 4'd15 : 4'd0;
      exp_v = {eg, ei, 1'b1, 1'b0};
      total++; if (obs !== exp_v) $display("FAIL rr_grant%0d got %h want %h", i, obs, exp_v); else passed++;
      done = 1'b1;
      tick();
      exp_v = {16'h0000, ei, 1'b0, 1'b0};
      total++; if (obs !== exp_v) $display("FAIL rr_gap%0d got %h want %h", i, obs, exp_v); else passed++;
      done = 1'b0;
      tick();
    end
    exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL rr_wrap got %h want %h", obs, exp_v); else passed++;
    req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_mask();
    mode = 1'b0; req = 16'h0003; mask = 16'h0001;
    tick();
    exp_v = {16'h0002, 4'd1, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL mask_grant got %h want %h", obs, exp_v); else passed++;
    mask = 16'h0003;
    tick();
    exp_v = {16'h0000, 4'd1, 1'b0, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL mask_release got %h want %h", obs, exp_v); else passed++;
    tick();
    total++; if (obs !== exp_v) $display("FAIL mask_idle got %h want %h", obs, exp_v); else passed++;
    mask = 16'h0000; req = 16'h0000;
    tick();
  endtask

  task automatic test_watchdog();
    req = 16'h0001;
    tick();
    for (int c = 1; c <= 4; c++) begin
      exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
      total++; if (obs !== exp_v) $display("FAIL wd_cycle%0d got %h want %h", c, obs, exp_v); else passed++;
      tick();
    end
    exp_v = {16'h0000, 4'd0, 1'b0, 1'b1};
    total++; if (obs !== exp_v) $display("FAIL wd_timeout got %h want %h", obs, exp_v); else passed++;
    tick();
    exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL wd_regrant got %h want %h", obs, exp_v); else passed++;
  endtask

  task automatic test_done_vs_timeout();
    tick();
    tick();
    tick();
    exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL dvt_cycle4 got %h want %h", obs, exp_v); else passed++;
    done = 1'b1;
    tick();
    exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL dvt_done_wins got %h want %h", obs, exp_v); else passed++;
    done = 1'b0;
    tick();
    exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL dvt_regrant got %h want %h", obs, exp_v); else passed++;
    en = 1'b0;
    tick();
    exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL en_drop got %h want %h", obs, exp_v); else passed++;
    done = 1'b1;
    tick();
    total++; if (obs !== exp_v) $display("FAIL en_idle got %h want %h", obs, exp_v); else passed++;
    en = 1'b1; done = 1'b0;
    tick();
    exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL en_regrant got %h want %h", obs, exp_v); else passed++;
    req = 16'h0000;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    en = 1'b1; mode = 1'b1; req = 16'h0080;
    tick();
    exp_v = {16'h0080, 4'd7, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL rst_pre_grant got %h want %h", obs, exp_v); else passed++;
    #2 resetn = 1'b0;
    #1;
    exp_v = {16'h0000, 4'd0, 1'b0, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL rst_async_drop got %h want %h", obs, exp_v); else passed++;
    #2 resetn = 1'b1;
    req = 16'h0081;
    tick();
    exp_v = {16'h0001, 4'd0, 1'b1, 1'b0};
    total++; if (obs !== exp_v) $display("FAIL rst_rr_ch0 got %h want %h", obs, exp_v); else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    clk = 1'b0; resetn = 1'b1;
    en = 1'b0; mode = 1'b0; req = 16'h0; mask = 16'h0; done = 1'b0;
    #1 resetn = 1'b0;
    test_reset();
    test_fixed();
    test_rr();
    test_mask();
    test_watchdog();
    test_done_vs_timeout();
    test_reset_mid_grant();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
